// File: rtl/mem_access_unit.sv
// Load/store sequencer between the datapath and a tri-state RAM bus.
// It takes one request at a time, adds bus wait states, extends load data and pulses done/error.
module mem_access_unit #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     address,
  inout  wire  [DATA_W-1:0]     data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   byte_en,
  input  logic                  mem_ready,
  output logic [2:0]            dbg_state,
  output logic                  dbg_data_oe
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  // Handshake: a request is taken only in IDLE when exactly one of req_read/req_write
  // is high; the bus access completes on a WAIT cycle with mem_ready high, and the
  // outcome is a single-cycle done or error pulse before the unit returns to IDLE.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t              state;
  logic [1:0]          size_q;
  logic                signed_q;
  logic                write_q;
  logic [LANE_W-1:0]   offset_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          wait_cnt;
  logic [7:0]          wait_cnt_next;
  logic                data_oe;

  logic [3:0]          req_bytes;
  logic                req_illegal;
  logic                req_misaligned;
  logic                req_both;
  logic [LANE_W-1:0]   req_offset;
  logic [NB-1:0]       req_be;

  always_comb begin
    req_bytes      = 4'd1 << req_size;
    req_illegal    = (int'(req_bytes) * 8) > DATA_W;
    req_misaligned = (req_addr[3:0] & (req_bytes - 4'd1)) != 4'd0;
    req_both       = req_read && req_write;
    req_offset     = req_addr[LANE_W-1:0];
    req_be         = '0;
    for (int i = 0; i < NB; i++) begin
      req_be[i] = (i >= int'(req_offset)) && (i < int'(req_offset) + int'(req_bytes));
    end
    wait_cnt_next  = wait_cnt + 8'd1;
  end

  // Extract a right-justified field of the given size and extend it to the bus width.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [1:0]        size,
                                               input logic              sgn);
    logic [DATA_W-1:0] res;
    logic              sbit;
    int                nbits;
    nbits = 8 << size;
    case (size)
      2'd0:    sbit = raw[7];
      2'd1:    sbit = raw[15];
      2'd2:    sbit = raw[(DATA_W >= 32) ? 31 : DATA_W-1];
      default: sbit = raw[DATA_W-1];
    endcase
    sbit = sbit & sgn;
    res  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      res[i] = (i < nbits) ? raw[i] : sbit;
    end
    return res;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      rdata     <= '0;
      address   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      byte_en   <= '0;
      data_oe   <= 1'b0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      write_q   <= 1'b0;
      offset_q  <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wait_cnt  <= 8'd0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_read || req_write) begin
            busy <= 1'b1;
            if (req_both || req_illegal || req_misaligned) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              size_q   <= req_size;
              signed_q <= req_signed;
              write_q  <= req_write;
              offset_q <= req_offset;
              be_q     <= req_be;
              wdata_q  <= req_wdata << {req_offset, 3'b000};
              address  <= req_addr;
              state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          mem_read  <= !write_q;
          mem_write <= write_q;
          byte_en   <= be_q;
          data_oe   <= write_q;
          wait_cnt  <= 8'd0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready || wait_cnt_next == TIMEOUT_CNT) begin
            address   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            byte_en   <= '0;
            data_oe   <= 1'b0;
            if (mem_ready) begin
              if (!write_q) begin
                rdata <= extend(data >> {offset_q, 3'b000}, size_q, signed_q);
              end
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end else begin
            wait_cnt <= wait_cnt_next;
          end
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The bus is only driven while a store is in WAIT; the enable clears asynchronously on reset.
  assign data        = data_oe ? wdata_q : 'z;
  assign dbg_state   = state;
  assign dbg_data_oe = data_oe;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver tasks issue requests and push expected
// responses; a monitor pops and compares whenever done or error pulses.
module tb_mem_access_unit;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int NB      = DATA_W / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_read, req_write, req_signed, mem_ready;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy, done, error, mem_read, mem_write, dbg_data_oe;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address;
  logic [NB-1:0]     byte_en;
  logic [2:0]        dbg_state;
  wire  [DATA_W-1:0] data;
  logic [DATA_W-1:0] bus_val;

  assign data = mem_read ? bus_val : 'z;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .error(error), .rdata(rdata), .address(address), .data(data),
    .mem_read(mem_read), .mem_write(mem_write), .byte_en(byte_en), .mem_ready(mem_ready),
    .dbg_state(dbg_state), .dbg_data_oe(dbg_data_oe)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] item;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (done || error) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_response: done=%0b error=%0b with nothing expected", done, error);
      end else begin
        item = exp_q.pop_front();
        check("resp_error", 64'(error), 64'(item[DATA_W]));
        check("resp_done", 64'(done), 64'(!item[DATA_W]));
        check("resp_rdata", rdata, item[DATA_W-1:0]);
      end
    end
  end

  // driver: one request, bus responder with 'waits' not-ready WAIT cycles
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                           input logic [63:0] wd, input int waits, input logic [63:0] bus,
                           input logic [7:0] exp_be, input logic [63:0] exp_bus,
                           input logic exp_err, input logic [63:0] exp_rd, input int exp_lat);
    int cyc;
    int wait_seen;
    bit finished;
    bit strobed;
    cyc = 0; wait_seen = 0; finished = 0; strobed = 0;
    @(negedge clock);
    req_read = rd; req_write = wr; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd; bus_val = bus;
    exp_q.push_back({exp_err, exp_rd});
    while (!finished && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        req_read = 1'b0; req_write = 1'b0;
        check($sformatf("%s_busy", name), 64'(busy), 64'd1);
        if (exp_lat > 1) begin
          check($sformatf("%s_setup_addr", name), 64'(address), 64'(addr));
          check($sformatf("%s_setup_strobe", name), 64'(mem_read | mem_write), 64'd0);
        end
      end
      if (mem_read || mem_write) begin
        strobed = 1;
        wait_seen++;
        if (wait_seen == 1) begin
          check($sformatf("%s_be", name), 64'(byte_en), 64'(exp_be));
          check($sformatf("%s_addr", name), 64'(address), 64'(addr));
          check($sformatf("%s_dir", name), 64'({mem_read, mem_write}), 64'({rd, wr}));
          if (wr) check($sformatf("%s_wbus", name), data, exp_bus);
        end
        mem_ready = (wait_seen > waits);
      end else begin
        mem_ready = 1'b0;
      end
      if (done || error) begin
        finished = 1;
        check($sformatf("%s_latency", name), 64'(cyc), 64'(exp_lat));
        check($sformatf("%s_strobed", name), 64'(strobed), 64'(exp_lat > 1));
        check($sformatf("%s_released", name), 64'({address != 0, byte_en != 0, dbg_data_oe}), 64'd0);
      end
    end
    mem_ready = 1'b0;
    if (!finished) begin
      n_checks++;
      $display("FAIL %s_timeout: no done/error within 40 cycles, expected latency %0d", name, exp_lat);
    end
    @(negedge clock);
    check($sformatf("%s_idle", name), 64'({busy, dbg_state}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_read = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = '0; req_wdata = '0; mem_ready = 0; bus_val = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pulses", 64'({done, error}), 64'd0);
    check("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
    check("rst_address", 64'(address), 64'd0);
    check("rst_byte_en", 64'(byte_en), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_data_oe", 64'(dbg_data_oe), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    //         name          rd wr sz sg addr    wdata                  waits bus                    be     exp_bus                err exp_rdata              lat
    do_access("st_dword",    0, 1, 3, 0, 32'h10, 64'h1122334455667788, 0,   64'h0,                 8'hFF, 64'h1122334455667788, 0, 64'h0,                 3);
    do_access("ld_sbyte",    1, 0, 0, 1, 32'h13, 64'h0,                2,   64'h00000000_80000000, 8'h08, 64'h0,                0, 64'hFFFFFFFFFFFFFF80,   5);
    do_access("ld_misalign", 1, 0, 1, 0, 32'h11, 64'h0,                0,   64'h0,                 8'h00, 64'h0,                1, 64'hFFFFFFFFFFFFFF80,   1);
    do_access("ld_timeout",  1, 0, 2, 0, 32'h20, 64'h0,                100, 64'h0,                 8'h0F, 64'h0,                1, 64'hFFFFFFFFFFFFFF80,   17);
    do_access("ld_uword",    1, 0, 2, 0, 32'h24, 64'h0,                1,   64'h89ABCDEF_00000000, 8'hF0, 64'h0,                0, 64'h00000000_89ABCDEF,  4);
    do_access("ld_shalf",    1, 0, 1, 1, 32'h06, 64'h0,                0,   64'h8001_0000_0000_0000, 8'hC0, 64'h0,              0, 64'hFFFFFFFFFFFF8001,   3);
    do_access("st_half",     0, 1, 1, 0, 32'h12, 64'hABCD,             0,   64'h0,                 8'h0C, 64'h00000000_ABCD0000, 0, 64'hFFFFFFFFFFFF8001,  3);
    do_access("ld_ubyte",    1, 0, 0, 0, 32'h07, 64'h0,                0,   64'hFE00_0000_0000_0000, 8'h80, 64'h0,              0, 64'h00000000000000FE,   3);
    do_access("ld_mis_dw",   1, 0, 3, 0, 32'h04, 64'h0,                0,   64'h0,                 8'h00, 64'h0,                1, 64'h00000000000000FE,   1);
    do_access("ld_last_wait",1, 0, 3, 1, 32'h18, 64'h0,                14,  64'h8000000000000001,  8'hFF, 64'h0,                0, 64'h8000000000000001,   17);
    do_access("st_byte",     0, 1, 0, 0, 32'h0D, 64'h5A,               0,   64'h0,                 8'h20, 64'h00005A00_00000000, 0, 64'h8000000000000001,  3);

    // reset asserted mid-store while in WAIT
    @(negedge clock);
    req_write = 1; req_size = 2'd3; req_addr = 32'h40; req_wdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clock);
    req_write = 0;
    @(negedge clock);
    check("mid_store_wait", 64'({mem_write, dbg_data_oe}), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_strobe", 64'({mem_read, mem_write}), 64'd0);
    check("mid_rst_data_oe", 64'(dbg_data_oe), 64'd0);
    check("mid_rst_state", 64'({busy, dbg_state}), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    do_access("both_req",    1, 1, 2, 0, 32'h08, 64'h0,                0,   64'h0,                 8'h00, 64'h0,                1, 64'h0,                  1);

    repeat (3) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
